// File: rtl/mask_encoder_32_to_5.sv
// Sequential 32-to-5 encoder: captures a register mask and emits the index of
// each set bit, one per valid/ready transfer, in LSB- or MSB-first order.
module mask_encoder_32_to_5 #(
    parameter int LSB_FIRST = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic [31:0] Mask,
    input  logic       Ready,
    output logic       Valid,
    output logic [4:0] Adr,
    output logic       Busy,
    output logic       Done,
    output logic [5:0] Count
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pending_q;
    logic [31:0] pending_d;
    logic [5:0]  count_q;
    logic [5:0]  count_d;
    logic        done_q;
    logic        done_d;

    logic [4:0]  adr_sel;
    logic [31:0] clr_bit;
    logic [31:0] pending_cleared;
    logic        xfer;

    // Lowest set index; later (lower) hits overwrite earlier ones.
    function automatic logic [4:0] lowest_index(input logic [31:0] p);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (p[i]) begin
                idx = i[4:0];
            end
        end
        return idx;
    endfunction

    function automatic logic [4:0] highest_index(input logic [31:0] p);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (p[i]) begin
                idx = i[4:0];
            end
        end
        return idx;
    endfunction

    always_comb begin
        if (LSB_FIRST != 0) begin
            adr_sel = lowest_index(pending_q);
        end else begin
            adr_sel = highest_index(pending_q);
        end
    end

    assign clr_bit         = 32'd1 << adr_sel;
    assign pending_cleared = pending_q & ~clr_bit;

    assign Valid = (state_q == SCAN);
    assign Busy  = (state_q == SCAN);
    assign Adr   = Valid ? adr_sel : 5'd0;
    assign Done  = done_q;
    assign Count = count_q;
    assign xfer  = Valid & Ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    pending_d = Mask;
                    count_d   = 6'd0;
                    if (Mask != 32'd0) begin
                        state_d = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (xfer) begin
                    pending_d = pending_cleared;
                    count_d   = count_q + 6'd1;
                    if (pending_cleared == 32'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset aborts any scan silently: no Done pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pending_q <= 32'd0;
            count_q   <= 6'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mask_encoder_32_to_5.sv
// Directed bench for mask_encoder_32_to_5: one LSB-first and one MSB-first
// instance share the same stimulus.
module tb_mask_encoder_32_to_5;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] mask;
    logic        ready;

    logic        valid_l, busy_l, done_l;
    logic [4:0]  adr_l;
    logic [5:0]  count_l;
    logic        valid_m, busy_m, done_m;
    logic [4:0]  adr_m;
    logic [5:0]  count_m;

    int vectors = 0;
    int miscompares = 0;

    mask_encoder_32_to_5 #(.LSB_FIRST(1)) dut_lsb (
        .Clk(clk), .Reset(reset), .Load(load), .Mask(mask), .Ready(ready),
        .Valid(valid_l), .Adr(adr_l), .Busy(busy_l), .Done(done_l), .Count(count_l)
    );

    mask_encoder_32_to_5 #(.LSB_FIRST(0)) dut_msb (
        .Clk(clk), .Reset(reset), .Load(load), .Mask(mask), .Ready(ready),
        .Valid(valid_m), .Adr(adr_m), .Busy(busy_m), .Done(done_m), .Count(count_m)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Common status check on the LSB-first instance.
    task automatic chk_l(input string tag, input logic v, input logic [4:0] a,
                         input logic d, input logic [5:0] c);
        chk({tag, "_valid"}, 32'(valid_l), 32'(v));
        chk({tag, "_busy"},  32'(busy_l),  32'(v));
        chk({tag, "_adr"},   32'(adr_l),   32'(a));
        chk({tag, "_done"},  32'(done_l),  32'(d));
        chk({tag, "_count"}, 32'(count_l), 32'(c));
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b1;
        mask  = 32'hFFFF_FFFF;
        ready = 1'b1;
        tick();
        tick();
        chk_l("reset", 1'b0, 5'd0, 1'b0, 6'd0);
        chk("reset_msb_valid", 32'(valid_m), 32'd0);

        reset = 1'b0;
        load  = 1'b0;
        tick();
        chk_l("idle", 1'b0, 5'd0, 1'b0, 6'd0);

        // Ordering: 0,4,31 LSB-first and 31,4,0 MSB-first.
        load = 1'b1;
        mask = 32'h8000_0011;
        tick();
        load = 1'b0;
        chk_l("ord1", 1'b1, 5'd0, 1'b0, 6'd0);
        chk("ord1_msb_adr", 32'(adr_m), 32'd31);
        tick();
        chk_l("ord2", 1'b1, 5'd4, 1'b0, 6'd1);
        chk("ord2_msb_adr", 32'(adr_m), 32'd4);
        tick();
        chk_l("ord3", 1'b1, 5'd31, 1'b0, 6'd2);
        chk("ord3_msb_adr", 32'(adr_m), 32'd0);
        tick();
        chk_l("ord_done", 1'b0, 5'd0, 1'b1, 6'd3);
        chk("ord_msb_done", 32'(done_m), 32'd1);
        chk("ord_msb_count", 32'(count_m), 32'd3);
        tick();
        chk_l("ord_after", 1'b0, 5'd0, 1'b0, 6'd3);

        // Backpressure: Adr=1 held four cycles, then Adr=2.
        ready = 1'b0;
        load  = 1'b1;
        mask  = 32'h0000_0006;
        tick();
        load = 1'b0;
        chk_l("bp1", 1'b1, 5'd1, 1'b0, 6'd0);
        chk("bp1_msb_adr", 32'(adr_m), 32'd2);
        tick();
        chk_l("bp2", 1'b1, 5'd1, 1'b0, 6'd0);
        tick();
        chk_l("bp3", 1'b1, 5'd1, 1'b0, 6'd0);
        tick();
        chk_l("bp4", 1'b1, 5'd1, 1'b0, 6'd0);
        ready = 1'b1;
        tick();
        chk_l("bp5", 1'b1, 5'd2, 1'b0, 6'd1);
        chk("bp5_msb_adr", 32'(adr_m), 32'd1);
        tick();
        chk_l("bp_done", 1'b0, 5'd0, 1'b1, 6'd2);

        // Zero mask: immediate Done, Count cleared, Valid never set.
        load = 1'b1;
        mask = 32'h0;
        tick();
        load = 1'b0;
        chk_l("zero_done", 1'b0, 5'd0, 1'b1, 6'd0);
        tick();
        chk_l("zero_after", 1'b0, 5'd0, 1'b0, 6'd0);

        // Full mask: 0..31 back to back, Done in cycle 33.
        load = 1'b1;
        mask = 32'hFFFF_FFFF;
        tick();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk_l($sformatf("full%0d", i), 1'b1, 5'(i), 1'b0, 6'(i));
            chk($sformatf("full%0d_dec", i), 32'd1 << adr_l, 32'd1 << i);
            chk($sformatf("full%0d_msb_adr", i), 32'(adr_m), 32'(31 - i));
            tick();
        end
        chk_l("full_done", 1'b0, 5'd0, 1'b1, 6'd32);
        chk("full_msb_count", 32'(count_m), 32'd32);
        tick();
        chk_l("full_after", 1'b0, 5'd0, 1'b0, 6'd32);

        // Load while busy is ignored; Load in the Done cycle is taken.
        load = 1'b1;
        mask = 32'h0000_0300;
        tick();
        mask = 32'h0000_0001;
        chk_l("busy1", 1'b1, 5'd8, 1'b0, 6'd0);
        chk("busy1_msb_adr", 32'(adr_m), 32'd9);
        tick();
        chk_l("busy2", 1'b1, 5'd9, 1'b0, 6'd1);
        load = 1'b0;
        tick();
        chk_l("busy_done", 1'b0, 5'd0, 1'b1, 6'd2);
        load = 1'b1;
        mask = 32'h0000_0020;
        tick();
        load = 1'b0;
        chk_l("donel1", 1'b1, 5'd5, 1'b0, 6'd0);
        tick();
        chk_l("donel_done", 1'b0, 5'd0, 1'b1, 6'd1);
        tick();

        // Reset mid-scan: back to IDLE with no Done pulse.
        load = 1'b1;
        mask = 32'h0000_00F0;
        tick();
        load = 1'b0;
        chk_l("rs1", 1'b1, 5'd4, 1'b0, 6'd0);
        reset = 1'b1;
        tick();
        chk_l("rs_reset", 1'b0, 5'd0, 1'b0, 6'd0);
        reset = 1'b0;
        tick();
        chk_l("rs_after", 1'b0, 5'd0, 1'b0, 6'd0);
        chk("rs_msb_done", 32'(done_m), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mask_encoder_32_to_5.md
# mask_encoder_32_to_5

Sequential 32-to-5 encoder: the inverse of the 5-to-32 register-address decoder. It captures a 32-bit mask (one bit per register) and emits the 5-bit address of each set bit, one per transfer, over a valid/ready handshake. It sits between mask-producing logic (register scan/dump, multi-register save/restore sequencing) and the register-file address port.

## Interface
- LSB_FIRST, default 1: 1 = emit lowest set index first; 0 = highest first.

- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  capture Mask; honoured only when Busy=0.
- Mask  in  32  register mask; bit i requests address i.
- Ready  in  1  consumer accepts Adr this cycle.
- Valid  out  1  Adr holds a pending address.
- Adr  out  5  current address; 0 when Valid=0.
- Busy  out  1  scan in progress (state SCAN).
- Done  out  1  one-cycle pulse after the scan completes.
- Count  out  6  addresses emitted by current/last scan, 0..32.

## Operation
- Reset (synchronous, active-high): state IDLE, pending register 0, Count 0; Valid, Adr, Busy, Done all 0. Reset wins over every other input, including mid-scan; no Done pulse on abort.
- States: IDLE, SCAN.
- IDLE:
  - Load=1 captures Mask into pending and clears Count.
  - Mask≠0: go to SCAN.
  - Mask=0: stay IDLE; Done=1 next cycle; Count stays 0.
  - Load=0: hold; Done returns to 0.
- SCAN:
  - Busy=1, Valid=1.
  - Adr is combinational from pending: lowest set index (LSB_FIRST=1) or highest (LSB_FIRST=0).
  - Transfer = Valid & Ready: clear bit Adr in pending, Count += 1.
  - If the cleared bit was the last set bit, go to IDLE; Done=1 in the next cycle.
  - Ready=0: pending, Adr and Count hold stable.
  - Load is ignored in SCAN.
- Count is 6 bits so a full mask reaches 32 without wrap. It is not cleared at scan end; it is cleared only by Reset or the next accepted Load.
- Load in the same cycle that Done=1 (IDLE) is accepted normally.
- Priority search is pure combinational over 32 bits. No multicycle or ripple state is allowed.

## Timing
- Load sampled at edge k → Valid=1 and first Adr visible after edge k (cycle k+1).
- Throughput: one address per cycle while Ready=1.
- Mask with N set bits and Ready held high: Valid for exactly N cycles (k+1..k+N), Done=1 in cycle k+N+1.
- Zero mask: Done=1 in cycle k+1, Valid never asserted.
- Busy is high exactly while Valid is high.
- Done is always a single-cycle pulse.
- Outputs Valid, Busy, Done, Count are registered or decoded from state. Adr is decoded from the registered pending value, with no combinational path from inputs to outputs.

## Test plan
- Reset check: assert Reset 2 cycles with Load=1, Mask=32'hFFFFFFFF → Valid, Busy, Done, Adr, Count all 0. Reset asserted mid-scan → IDLE next cycle, no Done pulse.
- Mask=32'h80000011, Ready=1, LSB_FIRST=1 → Adr 0, 4, 31 on three consecutive Valid cycles, then Done=1 for one cycle, Count=3. Same mask with LSB_FIRST=0 → Adr 31, 4, 0.
- Backpressure: Mask=32'h00000006, Ready=0 for 3 cycles then 1 → Adr=1 held stable for 4 cycles, then Adr=2 for 1 cycle, then Done, Count=2.
- Zero mask: Load with Mask=0 → Valid stays 0, Done=1 exactly in cycle after Load, Count=0.
- Full mask: Mask=32'hFFFFFFFF, Ready=1 → Adr 0..31 in 32 consecutive cycles, Count=32, Done at cycle 33. Each Adr decoded by the 5-to-32 decoder equals the bit cleared.
- Load during Busy (Mask=32'h00000001 while scanning 32'h00000300) is ignored → Adr 8, 9 only. Load in the Done cycle with Mask=32'h00000020 → Adr=5 in the following cycle.
